// File: rtl/spi_controller.sv
// SPI mode-0 write-only register controller: one 16-bit frame {1'b1, addr, data} per accepted request, done 35*CLK_DIV+1 cycles after accept.
// Backpressure: i_req_valid/o_req_ready handshake; o_req_ready is low for the whole frame, and a held request is taken on the done cycle.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [6:0] i_req_addr,
    input  logic [7:0] i_req_data,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_ncs,
    output logic       o_copi
);

    localparam logic [7:0] PHASE_MAX = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_phase;
    logic [3:0]  r_bit;
    logic        r_high;
    logic [15:0] r_shift;
    logic        r_ncs;
    logic        r_sclk;
    logic        r_copi;
    logic        r_done;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [7:0]  w_phase_nxt;
    logic [3:0]  w_bit_nxt;
    logic        w_high_nxt;
    logic [15:0] w_shift_nxt;
    logic        w_phase_end;
    logic        w_frame_nxt;

    assign w_phase_end = (r_phase == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_high_nxt  = r_high;
        w_shift_nxt = r_shift;

        if (r_state != ST_IDLE && !w_phase_end) begin
            w_phase_nxt = r_phase - 8'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_phase_nxt = PHASE_MAX;
                    w_shift_nxt = {1'b1, i_req_addr, i_req_data};
                end
            end
            ST_SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_SHIFT;
                    w_phase_nxt = PHASE_MAX;
                    w_bit_nxt   = 4'd15;
                    w_high_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_phase_end) begin
                    w_phase_nxt = PHASE_MAX;
                    if (!r_high) begin
                        w_high_nxt = 1'b1;
                    end else begin
                        w_high_nxt = 1'b0;
                        // Last bit stays in shift_reg[15] so HOLD keeps driving bit 0.
                        if (r_bit == 4'd0) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_bit_nxt   = r_bit - 4'd1;
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_GAP;
                    w_phase_nxt = PHASE_MAX;
                end
            end
            ST_GAP: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pin values are derived from the next state so they change on the same edge as the FSM.
    assign w_frame_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT) ||
                         (w_state_nxt == ST_HOLD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_phase <= 8'd0;
            r_bit   <= 4'd15;
            r_high  <= 1'b0;
            r_shift <= 16'd0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_high  <= w_high_nxt;
            r_shift <= w_shift_nxt;
            r_ncs   <= ~w_frame_nxt;
            r_sclk  <= (w_state_nxt == ST_SHIFT) && w_high_nxt;
            r_copi  <= w_frame_nxt && w_shift_nxt[15];
            r_done  <= (r_state == ST_GAP) && (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_sclk      = r_sclk;
    assign o_ncs       = r_ncs;
    assign o_copi      = r_copi;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: closed-form per-cycle pin model plus an SPI register target on the pins.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;
    logic       rdy0, done0, busy0, sclk0, ncs0, copi0;
    logic       rdy1, done1, busy1, sclk1, ncs1, copi1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: cycle of accept and frame word per instance.
    int          m_start [2];
    logic [15:0] m_word  [2];

    // Target peripheral observed on the pins.
    logic        prev_sclk [2];
    logic        prev_ncs  [2];
    logic [15:0] t_sh      [2];
    logic [15:0] last_word [2];
    int          t_cnt     [2];
    int          last_cnt  [2];
    int          last_rise [2];
    int          rise_int  [2];
    int          high_run  [2];
    int          gap_len   [2];
    int          first_low [2];
    int          last_low  [2];
    logic [7:0]  tregs     [2][128];

    spi_controller #(.CLK_DIV(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v0), .o_req_ready(rdy0),
        .i_req_addr(a0), .i_req_data(d0), .o_done(done0), .o_busy(busy0),
        .o_sclk(sclk0), .o_ncs(ncs0), .o_copi(copi0)
    );

    spi_controller #(.CLK_DIV(2)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_addr(a1), .i_req_data(d1), .o_done(done1), .o_busy(busy1),
        .o_sclk(sclk1), .o_ncs(ncs1), .o_copi(copi1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {rdy,done,busy,sclk,ncs,copi} t cycles after accept (t=0: idle).
    function automatic logic [5:0] model_out(input int t, input int D, input logic [15:0] w);
        logic [5:0] r;
        int u;
        r = 6'b100010;
        if (t >= 1 && t <= 35*D) begin
            r[5] = 1'b0;
            r[3] = 1'b1;
            if (t <= 34*D) r[1] = 1'b0;
            if (t >= D+1 && t <= 33*D) begin
                u = t - D - 1;
                r[2] = ((u % (2*D)) >= D);
                r[0] = w[15 - u/(2*D)];
            end else if (t <= D) begin
                r[0] = w[15];
            end else if (t <= 34*D) begin
                r[0] = w[0];
            end
        end else if (t == 35*D + 1) begin
            r[4] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_inst(input int n, input int D, input logic [5:0] got,
                              input logic vld, input logic [6:0] a, input logic [7:0] d);
        int t;
        logic [5:0] exp;
        t = (rst || m_start[n] < 0) ? 0 : cyc - m_start[n];
        exp = model_out(t, D, m_word[n]);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL pins inst%0d cyc %0d {rdy,done,busy,sclk,ncs,copi}: got %b expected %b",
                     n, cyc, got, exp);
        end
        if (rst) begin
            m_start[n] = -1;
        end else if (exp[5] && vld) begin
            m_start[n] = cyc;
            m_word[n]  = {1'b1, a, d};
        end

        if (!prev_sclk[n] && got[2] && !got[1]) begin
            t_sh[n]      = {t_sh[n][14:0], got[0]};
            t_cnt[n]     = t_cnt[n] + 1;
            rise_int[n]  = cyc - last_rise[n];
            last_rise[n] = cyc;
        end
        if (!got[1]) begin
            if (prev_ncs[n]) begin
                first_low[n] = cyc;
                gap_len[n]   = high_run[n];
            end
            last_low[n] = cyc;
            high_run[n] = 0;
        end else begin
            high_run[n] = high_run[n] + 1;
            if (!prev_ncs[n]) begin
                last_cnt[n] = t_cnt[n];
                if (t_cnt[n] == 16) begin
                    last_word[n] = t_sh[n];
                    if (t_sh[n][15]) tregs[n][t_sh[n][14:8]] = t_sh[n][7:0];
                end
                t_cnt[n] = 0;
            end
        end
        prev_sclk[n] = got[2];
        prev_ncs[n]  = got[1];
    endtask

    always @(negedge clk) begin
        check_inst(0, 4, {rdy0, done0, busy0, sclk0, ncs0, copi0}, v0, a0, d0);
        check_inst(1, 2, {rdy1, done1, busy1, sclk1, ncs1, copi1}, v1, a1, d1);
    end

    task automatic set_req(input int n, input logic v, input logic [6:0] a, input logic [7:0] d);
        if (n == 0) begin
            v0 = v; a0 = a; d0 = d;
        end else begin
            v1 = v; a1 = a; d1 = d;
        end
    endtask

    function automatic logic rdy_of(input int n);
        return (n == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic done_of(input int n);
        return (n == 0) ? done0 : done1;
    endfunction

    task automatic do_write(input int n, input logic [6:0] a, input logic [7:0] d,
                            input bit hold, output int acc);
        set_req(n, 1'b1, a, d);
        acc = -1;
        for (int k = 0; k < 400 && acc < 0; k++) begin
            if (rdy_of(n)) acc = cyc;
            @(posedge clk);
            #1;
        end
        if (!hold) set_req(n, 1'b0, a, d);
        if (acc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept timeout inst%0d: got no accept, required accept within 400 cycles", n);
        end
    endtask

    task automatic wait_done(input int n, output int dc);
        dc = -1;
        for (int k = 0; k < 400 && dc < 0; k++) begin
            @(posedge clk);
            #1;
            if (done_of(n)) dc = cyc;
        end
        if (dc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done timeout inst%0d: got no done, required done within 400 cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2, dc, rdy_hi;
        logic [7:0] tbl [5];
        tbl[0] = 8'h5A; tbl[1] = 8'hC3; tbl[2] = 8'h7E; tbl[3] = 8'h01; tbl[4] = 8'h80;
        for (int n = 0; n < 2; n++) begin
            m_start[n] = -1; m_word[n] = 16'd0;
            prev_sclk[n] = 1'b0; prev_ncs[n] = 1'b1; t_sh[n] = 16'd0; last_word[n] = 16'd0;
            t_cnt[n] = 0; last_cnt[n] = 0; last_rise[n] = 0; rise_int[n] = 0;
            high_run[n] = 0; gap_len[n] = 0; first_low[n] = 0; last_low[n] = 0;
            for (int r = 0; r < 128; r++) tregs[n][r] = 8'h00;
        end
        rst = 1'b1;
        v0 = 1'b0; a0 = 7'd0; d0 = 8'd0;
        v1 = 1'b0; a1 = 7'd0; d1 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ncs", int'(ncs0), 1);
        chk("reset ready", int'(rdy0), 1);
        rst = 1'b0;

        // Single write, D=4
        do_write(0, 7'h04, 8'hA5, 1'b0, acc);
        wait_done(0, dc);
        chk("t1 done latency", dc - acc, 141);
        chk("t1 first ncs low", first_low[0] - acc, 1);
        chk("t1 last ncs low", last_low[0] - acc, 136);
        chk("t1 sclk rises", last_cnt[0], 16);
        chk("t1 serial word", int'(last_word[0]), 16'h84A5);
        chk("t1 target reg4", int'(tregs[0][4]), 8'hA5);

        // Back-to-back with valid held
        do_write(0, 7'h00, 8'hFF, 1'b1, acc);
        do_write(0, 7'h01, 8'h0F, 1'b0, acc2);
        wait_done(0, dc);
        chk("t2 second accept on done", acc2 - acc, 141);
        chk("t2 ncs high gap", gap_len[0], 5);
        chk("t2 target reg0", int'(tregs[0][0]), 8'hFF);
        chk("t2 target reg1", int'(tregs[0][1]), 8'h0F);

        // Register peripheral programming
        for (int i = 0; i < 5; i++) begin
            do_write(0, 7'(i), tbl[i], 1'b0, acc);
            wait_done(0, dc);
        end
        for (int i = 0; i < 5; i++) chk("t3 target reg", int'(tregs[0][i]), int'(tbl[i]));

        // Reset at bit 7
        do_write(0, 7'h7F, 8'hAA, 1'b0, acc);
        repeat (68) @(posedge clk);
        #1;
        chk("t4 pre-reset ncs", int'(ncs0), 0);
        chk("t4 pre-reset copi bit7", int'(copi0), 1);
        rst = 1'b1;
        #1;
        chk("t4 reset ncs", int'(ncs0), 1);
        chk("t4 reset sclk", int'(sclk0), 0);
        chk("t4 reset copi", int'(copi0), 0);
        chk("t4 reset busy", int'(busy0), 0);
        chk("t4 reset ready", int'(rdy0), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4 partial frame rises", last_cnt[0], 8);
        do_write(0, 7'h02, 8'h3C, 1'b0, acc);
        wait_done(0, dc);
        chk("t4 serial word after reset", int'(last_word[0]), 16'h823C);
        chk("t4 target reg2", int'(tregs[0][2]), 8'h3C);
        chk("t4 aborted reg untouched", int'(tregs[0][127]), 8'h00);

        // Inputs change mid-frame
        do_write(0, 7'h05, 8'hC3, 1'b0, acc);
        d0 = 8'h00;
        a0 = 7'h06;
        rdy_hi = 0;
        for (int k = 0; k < 139; k++) begin
            if (rdy0) rdy_hi++;
            @(posedge clk);
            #1;
        end
        wait_done(0, dc);
        chk("t5 ready during frame", rdy_hi, 0);
        chk("t5 serial word", int'(last_word[0]), 16'h85C3);
        chk("t5 target reg5", int'(tregs[0][5]), 8'hC3);

        // D=2 instance
        do_write(1, 7'h03, 8'h81, 1'b0, acc);
        wait_done(1, dc);
        chk("t6 done latency", dc - acc, 71);
        chk("t6 first ncs low", first_low[1] - acc, 1);
        chk("t6 last ncs low", last_low[1] - acc, 68);
        chk("t6 sclk period", rise_int[1], 4);
        chk("t6 sclk rises", last_cnt[1], 16);
        chk("t6 serial word", int'(last_word[1]), 16'h8381);
        chk("t6 target reg3", int'(tregs[1][3]), 8'h81);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
